// File: rtl/debug_panel.sv
// Debug panel: byte-wise switch register entry, word-bank viewer with manual or auto-scroll,
// freeze snapshot and a latched clock-lock control, all driven from slide switches and two keys.
module debug_panel #(
   parameter int WORD_W     = 16,
   parameter int NUM_WORDS  = 32,
   parameter int SCROLL_DIV = 50000000,
   localparam int IDX_W  = $clog2(NUM_WORDS),
   localparam int LANES  = WORD_W / 8,
   localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1,
   localparam int CNT_W  = $clog2(SCROLL_DIV)
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic [9:0]                    i_sw,
   input  logic                          i_key_load,
   input  logic                          i_key_clear,
   input  logic [NUM_WORDS*WORD_W-1:0]   i_words,
   output logic [WORD_W-1:0]             o_switch_word,
   output logic [WORD_W-1:0]             o_view_word,
   output logic [IDX_W-1:0]              o_view_index,
   output logic [LANE_W-1:0]             o_lane_ptr,
   output logic                          o_clock_lock,
   output logic                          o_frozen,
   output logic                          o_any_nonzero
);

   logic [1:0]        r_load_sync, r_clear_sync;
   logic              r_load_prev, r_clear_prev;
   logic              r_load_arm, r_clear_arm;
   logic [1:0]        r_warm;
   logic [WORD_W-1:0] r_switch_word, r_view_word;
   logic [LANE_W-1:0] r_lane_ptr;
   logic [IDX_W-1:0]  r_view_index;
   logic [CNT_W-1:0]  r_scroll_cnt;
   logic              r_scroll_en, r_frozen, r_clock_lock, r_any_nonzero;

   logic              w_special, w_load_ev, w_clear_ev;
   logic              w_scroll_now, w_freeze_now, w_scroll_tc;
   logic [WORD_W-1:0] w_switch_next;
   logic [LANE_W-1:0] w_lane_next;
   logic [WORD_W-1:0] w_bank [NUM_WORDS];
   logic              w_unused_sw8;

   genvar g;
   generate
      for (g = 0; g < NUM_WORDS; g++) begin : g_bank
         assign w_bank[g] = i_words[g*WORD_W +: WORD_W];
      end
   endgenerate

   assign w_unused_sw8 = i_sw[8];
   assign w_special    = i_sw[9];

   // A key only arms once it has been seen released after reset, so a key held
   // through reset release never produces an event.
   assign w_load_ev  = r_load_sync[1]  & ~r_load_prev  & r_load_arm;
   assign w_clear_ev = r_clear_sync[1] & ~r_clear_prev & r_clear_arm;

   assign w_scroll_now = w_special ? i_sw[7] : r_scroll_en;
   assign w_freeze_now = w_special ? i_sw[6] : r_frozen;
   assign w_scroll_tc  = (r_scroll_cnt == CNT_W'(SCROLL_DIV - 1));

   always_comb begin
      w_switch_next = r_switch_word;
      w_lane_next   = r_lane_ptr;
      if (!w_special) begin
         if (w_clear_ev) begin
            w_switch_next = '0;
            w_lane_next   = '0;
         end else if (w_load_ev) begin
            for (int l = 0; l < LANES; l++) begin
               if (LANE_W'(l) == r_lane_ptr) w_switch_next[l*8 +: 8] = i_sw[7:0];
            end
            w_lane_next = (r_lane_ptr == LANE_W'(LANES - 1)) ? '0 : r_lane_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_load_sync   <= '0;
         r_clear_sync  <= '0;
         r_load_prev   <= 1'b0;
         r_clear_prev  <= 1'b0;
         r_load_arm    <= 1'b0;
         r_clear_arm   <= 1'b0;
         r_warm        <= '0;
         r_switch_word <= '0;
         r_lane_ptr    <= '0;
         r_view_word   <= '0;
         r_view_index  <= '0;
         r_scroll_cnt  <= '0;
         r_scroll_en   <= 1'b0;
         r_frozen      <= 1'b0;
         r_clock_lock  <= 1'b0;
         r_any_nonzero <= 1'b0;
      end else begin
         r_load_sync  <= {r_load_sync[0], i_key_load};
         r_clear_sync <= {r_clear_sync[0], i_key_clear};
         r_load_prev  <= r_load_sync[1];
         r_clear_prev <= r_clear_sync[1];
         r_warm       <= {r_warm[0], 1'b1};
         if (r_warm[1] && !r_load_sync[1])  r_load_arm  <= 1'b1;
         if (r_warm[1] && !r_clear_sync[1]) r_clear_arm <= 1'b1;

         r_switch_word <= w_switch_next;
         r_lane_ptr    <= w_lane_next;
         r_any_nonzero <= |r_switch_word;

         if (w_special) r_clock_lock <= i_sw[5];
         r_scroll_en <= w_scroll_now;
         r_frozen    <= w_freeze_now;

         if (w_scroll_now) begin
            if (w_scroll_tc) begin
               r_scroll_cnt <= '0;
               r_view_index <= r_view_index + 1'b1;
            end else begin
               r_scroll_cnt <= r_scroll_cnt + 1'b1;
            end
         end else begin
            r_scroll_cnt <= '0;
            if (w_special) r_view_index <= i_sw[IDX_W-1:0];
         end

         if (!w_freeze_now) r_view_word <= w_bank[r_view_index];
      end
   end

   assign o_switch_word = r_switch_word;
   assign o_view_word   = r_view_word;
   assign o_view_index  = r_view_index;
   assign o_lane_ptr    = r_lane_ptr;
   assign o_clock_lock  = r_clock_lock;
   assign o_frozen      = r_frozen;
   assign o_any_nonzero = r_any_nonzero;

endmodule
